wb_ram_mp: RTL and testbench

- Parametrised multi-port, multi-bank Wishbone (pipelined, stall/ack) SRAM. Successor to the fixed two-port RAM.
- NUM_PORTS masters share NUM_BANKS independent word banks; each bank has its own round-robin arbiter.
- Ports targeting different banks proceed in the same cycle; only same-bank collisions stall.
- Sits on the SoC Wishbone fabric as shared scratch/data memory between CPU, DMA and peripherals.

---
 rtl/wb_itf.sv | 44 ++++
 rtl/wb_ram_mp_if.sv | 13 +
 rtl/wb_ram_bank.sv | 67 ++++++
 rtl/wb_ram_mp.sv | 103 ++++++++++
 tb/tb_wb_ram_mp.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_itf.sv
// Shared Wishbone pipelined-mode payload types and a reusable round-robin picker.
package wb_itf;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned SEL_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned MAX_PORTS  = 8;
  localparam int unsigned PORT_IDX_W = $clog2(MAX_PORTS);

  typedef struct packed {
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [SEL_WIDTH-1:0]  sel;
  } wb_input_t;

  typedef struct packed {
    logic                  ack;
    logic                  stall;
    logic [DATA_WIDTH-1:0] data;
  } wb_output_t;

  // One-hot grant: first requester found scanning upward from the port after last, wrapping at n.
  function automatic logic [MAX_PORTS-1:0] rr_pick(input logic [MAX_PORTS-1:0]  req,
                                                   input logic [PORT_IDX_W-1:0] last,
                                                   input int unsigned           n);
    logic [MAX_PORTS-1:0]  gnt;
    logic                  found;
    logic [PORT_IDX_W-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_PORTS; i++) begin
      idx = PORT_IDX_W'((32'(last) + i) % n);
      if ((i <= n) && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/wb_ram_mp_if.sv
// Bundle of per-port Wishbone request/response payloads for the multi-port RAM.
interface wb_ram_mp_if #(
  parameter int unsigned NUM_PORTS = 2
);
  import wb_itf::*;

  wb_input_t  p_wb_i [NUM_PORTS];
  wb_output_t p_wb_o [NUM_PORTS];

  modport master (output p_wb_i, input  p_wb_o);
  modport slave  (input  p_wb_i, output p_wb_o);

endinterface

// File: rtl/wb_ram_bank.sv
// One RAM bank: round-robin arbiter over all ports, byte-masked write, winner's word on rdata_c.
module wb_ram_bank
  import wb_itf::*;
#(
  parameter  int unsigned NUM_PORTS      = 2,
  parameter  int unsigned WORDS_PER_BANK = 256,
  localparam int unsigned WORD_BITS      = $clog2(WORDS_PER_BANK)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0]                 req,
  input  logic [NUM_PORTS-1:0][WORD_BITS-1:0]  word_idx,
  input  logic [NUM_PORTS-1:0]                 we,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata,
  input  logic [NUM_PORTS-1:0][SEL_WIDTH-1:0]  sel,
  output logic [NUM_PORTS-1:0]                 grant_c,
  output logic [DATA_WIDTH-1:0]                rdata_c
);

  localparam int unsigned PORT_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PORT_BITS-1:0]  last_q, last_d;
  logic                  win_valid;
  logic [WORD_BITS-1:0]  win_idx;
  logic                  win_we;
  logic [DATA_WIDTH-1:0] win_data;
  logic [SEL_WIDTH-1:0]  win_sel;
  logic [DATA_WIDTH-1:0] mem [WORDS_PER_BANK];

  // Arbitrate and steer the single winning port's request onto the bank.
  always_comb begin
    grant_c   = NUM_PORTS'(rr_pick(MAX_PORTS'(req), PORT_IDX_W'(last_q), NUM_PORTS));
    last_d    = last_q;
    win_valid = 1'b0;
    win_idx   = '0;
    win_we    = 1'b0;
    win_data  = '0;
    win_sel   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_c[p]) begin
        last_d    = PORT_BITS'(p);
        win_valid = 1'b1;
        win_idx   = word_idx[p];
        win_we    = we[p];
        win_data  = wdata[p];
        win_sel   = sel[p];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= PORT_BITS'(NUM_PORTS - 1);
    else     last_q <= last_d;
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (win_valid && win_we) begin
      for (int i = 0; i < SEL_WIDTH; i++) begin
        if (win_sel[i]) mem[win_idx][8*i +: 8] <= win_data[8*i +: 8];
      end
    end
  end

  assign rdata_c = mem[win_idx];

endmodule

// File: rtl/wb_ram_mp.sv
// Multi-port, multi-bank pipelined Wishbone SRAM: address decode, bank fan-out, per-port ack/data.
module wb_ram_mp
  import wb_itf::*;
#(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned NUM_BANKS      = 2,
  parameter int unsigned WORDS_PER_BANK = 256
) (
  input logic        wb_clk,
  input logic        wb_reset,
  wb_ram_mp_if.slave bus
);

  localparam int unsigned BANK_BITS  = $clog2(NUM_BANKS);
  localparam int unsigned WORD_BITS  = $clog2(WORDS_PER_BANK);
  localparam int unsigned BANK_SEL_W = (BANK_BITS > 0) ? BANK_BITS : 1;

  if (64'(4) * 64'(NUM_BANKS) * 64'(WORDS_PER_BANK) > (64'(1) << ADDR_WIDTH)) begin : g_size_err
    $fatal(1, "wb_ram_mp: banks exceed the address space");
  end
  if ((NUM_PORTS < 1) || (NUM_PORTS > MAX_PORTS)) begin : g_port_err
    $fatal(1, "wb_ram_mp: NUM_PORTS out of range");
  end

  logic [NUM_PORTS-1:0]                  active_c, we_c, grant_c, stall_c, accept_c;
  logic [NUM_PORTS-1:0][WORD_BITS-1:0]   word_c;
  logic [NUM_PORTS-1:0][BANK_SEL_W-1:0]  bank_c;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  wdata_c;
  logic [NUM_PORTS-1:0][SEL_WIDTH-1:0]   sel_c;
  logic [NUM_BANKS-1:0][NUM_PORTS-1:0]   bank_req_c, bank_grant_c;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  bank_rdata_c;
  logic [NUM_PORTS-1:0]                  ack_q, ack_d;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  data_q, data_d;

  // Byte offset and bits above the bank field are ignored, so upper addresses alias.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
    assign active_c[p] = bus.p_wb_i[p].cyc & bus.p_wb_i[p].stb;
    assign we_c[p]     = bus.p_wb_i[p].we;
    assign word_c[p]   = bus.p_wb_i[p].addr[2 +: WORD_BITS];
    assign wdata_c[p]  = bus.p_wb_i[p].data;
    assign sel_c[p]    = bus.p_wb_i[p].sel;
    if (BANK_BITS > 0) begin : g_bank
      assign bank_c[p] = bus.p_wb_i[p].addr[2+WORD_BITS +: BANK_SEL_W];
    end else begin : g_one
      assign bank_c[p] = '0;
    end
    assign bus.p_wb_o[p] = '{ack: ack_q[p], stall: stall_c[p], data: data_q[p]};
  end

  always_comb begin
    bank_req_c = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        bank_req_c[b][p] = active_c[p] && (bank_c[p] == BANK_SEL_W'(b));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank_inst
    wb_ram_bank #(
      .NUM_PORTS     (NUM_PORTS),
      .WORDS_PER_BANK(WORDS_PER_BANK)
    ) u_bank (
      .clk     (wb_clk),
      .rst     (wb_reset),
      .req     (bank_req_c[b]),
      .word_idx(word_c),
      .we      (we_c),
      .wdata   (wdata_c),
      .sel     (sel_c),
      .grant_c (bank_grant_c[b]),
      .rdata_c (bank_rdata_c[b])
    );
  end

  // Each port requests at most one bank, so OR-ing grants across banks is exact.
  always_comb begin
    grant_c = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        grant_c[p] = grant_c[p] | bank_grant_c[b][p];
      end
    end
    stall_c  = active_c & ~grant_c;
    accept_c = active_c & grant_c;
    ack_d    = accept_c;
    data_d   = data_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (accept_c[p] && !we_c[p]) data_d[p] = bank_rdata_c[bank_c[p]];
    end
  end

  always_ff @(posedge wb_clk or posedge wb_reset) begin
    if (wb_reset) begin
      ack_q  <= '0;
      data_q <= '0;
    end else begin
      ack_q  <= ack_d;
      data_q <= data_d;
    end
  end

endmodule

// File: tb/tb_wb_ram_mp.sv
// Self-checking bench for wb_ram_mp: directed sequences, byte-select table, randomized model compare.
module tb_wb_ram_mp;
  import wb_itf::*;

  localparam int NP  = 2;
  localparam int NB  = 2;
  localparam int WPB = 256;
  localparam int RW  = 8;   // words per bank exercised by the random phase

  logic wb_clk;
  logic wb_reset;

  wb_ram_mp_if #(.NUM_PORTS(NP)) bus ();

  wb_ram_mp #(
    .NUM_PORTS     (NP),
    .NUM_BANKS     (NB),
    .WORDS_PER_BANK(WPB)
  ) dut (
    .wb_clk  (wb_clk),
    .wb_reset(wb_reset),
    .bus     (bus)
  );

  initial begin
    wb_clk = 1'b0;
    forever #5 wb_clk = ~wb_clk;
  end

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] exp;
  } bsel_vec_t;

  bsel_vec_t vec [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for grant (t=%0t)", name, $time);
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic idle_port(input int p);
    bus.p_wb_i[p] = '0;
  endtask

  task automatic set_req(input int p, input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] sel);
    bus.p_wb_i[p] = '{cyc: 1'b1, stb: 1'b1, we: we, addr: addr, data: data, sel: sel};
  endtask

  // Single transaction on port p; returns at posedge+1 of the ack cycle.
  task automatic xfer(input int p, input logic we, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] sel, output logic [31:0] rd);
    bit done;
    done = 1'b0;
    rd   = '0;
    set_req(p, we, addr, data, sel);
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge wb_clk);
      if (!bus.p_wb_o[p].stall) begin
        tick();
        idle_port(p);
        check("xfer_ack", 32'(bus.p_wb_o[p].ack), 32'(1));
        rd   = bus.p_wb_o[p].data;
        done = 1'b1;
      end else begin
        tick();
      end
    end
    if (!done) begin
      idle_port(p);
      fail_now("xfer_wait");
    end
  endtask

  task automatic do_reset();
    for (int p = 0; p < NP; p++) idle_port(p);
    wb_reset = 1'b1;
    tick();
    tick();
    wb_reset = 1'b0;
  endtask

  function automatic logic [31:0] mk_addr(input int b, input int w);
    logic [31:0] a;
    a = ($urandom & 32'hFFFF_F800) | (32'(b) << 10) | (32'(w) << 2) | ($urandom & 32'h3);
    return a;
  endfunction

  // Reference model state for the random phase.
  logic [31:0] m_mem [NB*RW];
  int          m_last [NB];
  logic [31:0] m_data [NP];

  initial begin
    logic [31:0] rd;
    logic [31:0] pexp [3];
    logic [31:0] paddr [3];
    n_cmp = 0;
    n_bad = 0;

    vec[0]  = '{4'h0, 32'hFFFF_FFFF}; vec[1]  = '{4'h1, 32'hFFFF_FF04};
    vec[2]  = '{4'h2, 32'hFFFF_03FF}; vec[3]  = '{4'h3, 32'hFFFF_0304};
    vec[4]  = '{4'h4, 32'hFF02_FFFF}; vec[5]  = '{4'h5, 32'hFF02_FF04};
    vec[6]  = '{4'h6, 32'hFF02_03FF}; vec[7]  = '{4'h7, 32'hFF02_0304};
    vec[8]  = '{4'h8, 32'h01FF_FFFF}; vec[9]  = '{4'h9, 32'h01FF_FF04};
    vec[10] = '{4'hA, 32'h01FF_03FF}; vec[11] = '{4'hB, 32'h01FF_0304};
    vec[12] = '{4'hC, 32'h0102_FFFF}; vec[13] = '{4'hD, 32'h0102_FF04};
    vec[14] = '{4'hE, 32'h0102_03FF}; vec[15] = '{4'hF, 32'h0102_0304};

    // Reset state
    wb_reset = 1'b1;
    for (int p = 0; p < NP; p++) idle_port(p);
    tick();
    tick();
    for (int p = 0; p < NP; p++) begin
      check("rst_ack",   32'(bus.p_wb_o[p].ack),   32'(0));
      check("rst_data",  bus.p_wb_o[p].data,       32'h0);
      check("rst_stall", 32'(bus.p_wb_o[p].stall), 32'(0));
    end
    wb_reset = 1'b0;
    tick();

    // Basic write, single-cycle ack, read back from the other port
    xfer(0, 1'b1, 32'h004, 32'hCAFE_BABE, 4'hF, rd);
    tick();
    check("ack_one_cycle", 32'(bus.p_wb_o[0].ack), 32'(0));
    xfer(1, 1'b0, 32'h004, 32'h0, 4'hF, rd);
    check("basic_read", rd, 32'hCAFE_BABE);

    // Byte-select sweep
    for (int i = 0; i < 16; i++) begin
      xfer(0, 1'b1, 32'h010, 32'hFFFF_FFFF, 4'hF, rd);
      xfer(0, 1'b1, 32'h010, 32'h0102_0304, vec[i].sel, rd);
      xfer(1, 1'b0, 32'h010, 32'h0, 4'h0, rd);
      check($sformatf("bytesel_%0h", vec[i].sel), rd, vec[i].exp);
    end

    // Different banks in the same cycle
    set_req(0, 1'b1, 32'h004, 32'h1111_2222, 4'hF);
    set_req(1, 1'b1, 32'h404, 32'h3333_4444, 4'hF);
    @(negedge wb_clk);
    check("par_stall0", 32'(bus.p_wb_o[0].stall), 32'(0));
    check("par_stall1", 32'(bus.p_wb_o[1].stall), 32'(0));
    tick();
    idle_port(0);
    idle_port(1);
    check("par_ack0", 32'(bus.p_wb_o[0].ack), 32'(1));
    check("par_ack1", 32'(bus.p_wb_o[1].ack), 32'(1));
    xfer(1, 1'b0, 32'h004, 32'h0, 4'hF, rd);
    check("par_rd0", rd, 32'h1111_2222);
    xfer(0, 1'b0, 32'h404, 32'h0, 4'hF, rd);
    check("par_rd1", rd, 32'h3333_4444);

    // Same-bank collision held for 10 transactions: A first, then alternate
    do_reset();
    set_req(0, 1'b1, 32'h004, 32'hDEAD_BEEF, 4'hF);
    set_req(1, 1'b1, 32'h008, 32'hCAFE_BABE, 4'hF);
    for (int k = 0; k < 10; k++) begin
      @(negedge wb_clk);
      check($sformatf("col_stallA_%0d", k), 32'(bus.p_wb_o[0].stall), 32'(k % 2));
      check($sformatf("col_stallB_%0d", k), 32'(bus.p_wb_o[1].stall), 32'((k + 1) % 2));
      tick();
      check($sformatf("col_ackA_%0d", k), 32'(bus.p_wb_o[0].ack), 32'((k + 1) % 2));
      check($sformatf("col_ackB_%0d", k), 32'(bus.p_wb_o[1].ack), 32'(k % 2));
    end
    idle_port(0);
    idle_port(1);
    tick();
    check("col_ack_drop", 32'({bus.p_wb_o[1].ack, bus.p_wb_o[0].ack}), 32'(0));
    xfer(1, 1'b0, 32'h004, 32'h0, 4'hF, rd);
    check("col_rdA", rd, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 32'h008, 32'h0, 4'hF, rd);
    check("col_rdB", rd, 32'hCAFE_BABE);

    // Pipelined reads on consecutive cycles
    xfer(1, 1'b1, 32'h000, 32'h1357_2468, 4'hF, rd);
    paddr[0] = 32'h000; paddr[1] = 32'h004; paddr[2] = 32'h008;
    pexp[0]  = 32'h1357_2468; pexp[1] = 32'hDEAD_BEEF; pexp[2] = 32'hCAFE_BABE;
    set_req(0, 1'b0, paddr[0], 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk);
      check($sformatf("pipe_stall_%0d", i), 32'(bus.p_wb_o[0].stall), 32'(0));
      tick();
      if (i < 2) set_req(0, 1'b0, paddr[i+1], 32'h0, 4'h0);
      else       idle_port(0);
      check($sformatf("pipe_ack_%0d", i), 32'(bus.p_wb_o[0].ack), 32'(1));
      check($sformatf("pipe_data_%0d", i), bus.p_wb_o[0].data, pexp[i]);
    end
    tick();
    check("pipe_ack_end", 32'(bus.p_wb_o[0].ack), 32'(0));

    // Reset right after an accepted read cancels the ack and clears data
    set_req(0, 1'b0, 32'h404, 32'h0, 4'hF);
    tick();
    wb_reset = 1'b1;
    idle_port(0);
    #1;
    check("rstmid_ack",  32'(bus.p_wb_o[0].ack), 32'(0));
    check("rstmid_data", bus.p_wb_o[0].data,     32'h0);
    tick();
    tick();
    wb_reset = 1'b0;
    set_req(0, 1'b0, 32'h000, 32'h0, 4'hF);
    set_req(1, 1'b0, 32'h004, 32'h0, 4'hF);
    @(negedge wb_clk);
    check("rstmid_stall0", 32'(bus.p_wb_o[0].stall), 32'(0));
    check("rstmid_stall1", 32'(bus.p_wb_o[1].stall), 32'(1));
    tick();
    idle_port(0);
    idle_port(1);
    check("rstmid_ack0",  32'(bus.p_wb_o[0].ack), 32'(1));
    check("rstmid_data0", bus.p_wb_o[0].data,     32'h1357_2468);
    xfer(1, 1'b0, 32'h404, 32'h0, 4'hF, rd);
    check("retained_404", rd, 32'h3333_4444);

    // Randomized phase against the reference model
    for (int b = 0; b < NB; b++) begin
      for (int w = 0; w < RW; w++) begin
        xfer(0, 1'b1, mk_addr(b, w), 32'h0, 4'hF, rd);
        m_mem[b*RW + w] = 32'h0;
      end
    end
    do_reset();
    for (int b = 0; b < NB; b++) m_last[b] = NP - 1;
    for (int p = 0; p < NP; p++) m_data[p] = 32'h0;

    for (int c = 0; c < 300; c++) begin
      bit          t_act [NP];
      bit          t_we [NP];
      int          t_bank [NP];
      int          t_word [NP];
      logic [31:0] t_data [NP];
      logic [3:0]  t_sel [NP];
      bit          t_gnt [NP];
      for (int p = 0; p < NP; p++) begin
        logic cyc_b, stb_b;
        cyc_b     = ($urandom_range(0, 7) != 0);
        stb_b     = ($urandom_range(0, 3) != 0);
        t_act[p]  = cyc_b & stb_b;
        t_we[p]   = $urandom_range(0, 1) != 0;
        t_bank[p] = $urandom_range(0, NB - 1);
        t_word[p] = $urandom_range(0, RW - 1);
        t_data[p] = $urandom;
        t_sel[p]  = 4'($urandom_range(0, 15));
        t_gnt[p]  = 1'b0;
        bus.p_wb_i[p] = '{cyc: cyc_b, stb: stb_b, we: t_we[p],
                          addr: mk_addr(t_bank[p], t_word[p]), data: t_data[p], sel: t_sel[p]};
      end
      for (int b = 0; b < NB; b++) begin
        int winner;
        winner = -1;
        for (int i = 1; i <= NP; i++) begin
          int q;
          q = (m_last[b] + i) % NP;
          if (winner < 0 && t_act[q] && t_bank[q] == b) winner = q;
        end
        if (winner >= 0) begin
          t_gnt[winner] = 1'b1;
          m_last[b]     = winner;
        end
      end
      @(negedge wb_clk);
      for (int p = 0; p < NP; p++) begin
        check($sformatf("rnd_stall_p%0d_c%0d", p, c), 32'(bus.p_wb_o[p].stall),
              32'(t_act[p] && !t_gnt[p]));
      end
      for (int p = 0; p < NP; p++) begin
        if (t_gnt[p]) begin
          int idx;
          idx = t_bank[p] * RW + t_word[p];
          if (t_we[p]) begin
            for (int i = 0; i < 4; i++) begin
              if (t_sel[p][i]) m_mem[idx][8*i +: 8] = t_data[p][8*i +: 8];
            end
          end else begin
            m_data[p] = m_mem[idx];
          end
        end
      end
      tick();
      for (int p = 0; p < NP; p++) begin
        check($sformatf("rnd_ack_p%0d_c%0d", p, c), 32'(bus.p_wb_o[p].ack), 32'(t_gnt[p]));
        check($sformatf("rnd_data_p%0d_c%0d", p, c), bus.p_wb_o[p].data, m_data[p]);
      end
    end
    for (int p = 0; p < NP; p++) idle_port(p);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
